mul16_seq_ctrl: RTL and testbench

MUL16_SEQ_CTRL -- requirements
Module: mul16_seq_ctrl

---
 rtl/mul16_seq_ctrl.sv | 93 +++++++++
 tb/tb_mul16_seq_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mul16_seq_ctrl.sv
// Sequential 16x16 unsigned shift-and-add multiplier, one partial product per clock.
// Optional macro MUL16_ZERO_SKIP_EN: a zero operand finishes one cycle after acceptance.
module mul16_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [31:0] acc;
    logic [3:0]  cnt;
    logic [31:0] pp_shifted;
    logic [31:0] acc_next;
`ifdef MUL16_ZERO_SKIP_EN
    logic        skip;
`endif

    // Partial product for the current multiplier bit, aligned to its weight.
    always_comb begin
        pp_shifted = {16'd0, a_reg & {16{b_reg[cnt]}}} << cnt;
        acc_next   = acc + pp_shifted;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= 16'd0;
            b_reg   <= 16'd0;
            acc     <= 32'd0;
            cnt     <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= 32'd0;
`ifdef MUL16_ZERO_SKIP_EN
            skip    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= 32'd0;
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef MUL16_ZERO_SKIP_EN
                        skip  <= (a == 16'd0) || (b == 16'd0);
`endif
                    end
                end
                RUN: begin
`ifdef MUL16_ZERO_SKIP_EN
                    if (skip) begin
                        product <= 32'd0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        skip    <= 1'b0;
                        state   <= IDLE;
                    end else
`endif
                    begin
                        acc <= acc_next;
                        // Step 15 always terminates; cnt is never allowed to wrap into a 17th step.
                        if (cnt == 4'd15) begin
                            product <= acc_next;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Self-checking bench for mul16_seq_ctrl: directed table, corner-case sequences, random pairs.
// Expected latency follows MUL16_ZERO_SKIP_EN when the bench is built with it.
module tb_mul16_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int done_time;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
    } vec_t;

    vec_t vecs [8];

    mul16_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_in),
        .b       (b_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic int expLat(input logic [15:0] x, input logic [15:0] y);
`ifdef MUL16_ZERO_SKIP_EN
        return ((x == 16'd0) || (y == 16'd0)) ? 1 : 16;
`else
        return 16;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Presents operands with start for exactly one edge; returns 1ns after that edge.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y);
        a_in  = x;
        b_in  = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done, checking latency, busy length, product, and that product held during the run.
    task automatic waitDone(input string name, input logic [31:0] exp_prod, input int exp_lat, input bit disturb);
        int lat;
        int busy_cnt;
        bit held;
        logic [31:0] prev;
        prev     = product;
        held     = 1'b1;
        busy_cnt = busy ? 1 : 0;
        lat      = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
            if (busy) busy_cnt++;
            if (product !== prev) held = 1'b0;
            if (disturb) begin
                a_in  = ~a_in;
                b_in  = b_in ^ 16'h5A5A;
                start = ~start;
            end
        end
        start = 1'b0;
        done_time = cycle;
        checkOutput({name, " done_seen"}, {31'd0, done}, 32'd1);
        checkOutput({name, " latency"}, lat, exp_lat);
        checkOutput({name, " busy_cycles"}, busy_cnt, exp_lat);
        checkOutput({name, " product"}, product, exp_prod);
        checkOutput({name, " product_held"}, {31'd0, held}, 32'd1);
    endtask

    initial begin
        int t1;
        int seen;
        logic [15:0] ra;
        logic [15:0] rb;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h1234, 16'h0010, 32'h00012340};
        vecs[3] = '{16'h0000, 16'h1234, 32'h00000000};
        vecs[4] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[5] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
        vecs[6] = '{16'h1234, 16'h0000, 32'h00000000};
        vecs[7] = '{16'h00FF, 16'h0101, 32'h0000FFFF};

        rst   = 1'b1;
        start = 1'b0;
        a_in  = 16'd0;
        b_in  = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset product", product, 32'd0);

        // First vector is started on the very first edge with rst low.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            waitDone($sformatf("vec%0d", i), vecs[i].prod, expLat(vecs[i].a, vecs[i].b), 1'b0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d done_one_cycle", i), {31'd0, done}, 32'd0);
        end

        $display("[TB] busy-time start pulses and operand changes");
        applyStimulus(16'hFFFF, 16'hFFFF);
        waitDone("disturbed", 32'hFFFE0001, 16, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("disturbed no_restart", {31'd0, busy}, 32'd0);

        $display("[TB] back-to-back operations");
        applyStimulus(16'h1234, 16'h0010);
        waitDone("b2b first", 32'h00012340, 16, 1'b0);
        t1 = done_time;
        applyStimulus(16'h0002, 16'h0003);
        waitDone("b2b second", 32'h00000006, 16, 1'b0);
        checkOutput("b2b done_spacing", done_time - t1, 17);

        $display("[TB] reset during run");
        applyStimulus(16'hABCD, 16'h1111);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrun_rst busy", {31'd0, busy}, 32'd0);
        checkOutput("midrun_rst done", {31'd0, done}, 32'd0);
        checkOutput("midrun_rst product", product, 32'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        checkOutput("midrun_rst no_done", seen, 0);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_over_start busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        applyStimulus(16'h0007, 16'h0009);
        waitDone("after_rst", 32'h0000003F, 16, 1'b0);

        $display("[TB] random operand pairs");
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            @(posedge clk);
            #1;
            applyStimulus(ra, rb);
            waitDone($sformatf("rand%0d", i), {16'd0, ra} * {16'd0, rb}, expLat(ra, rb), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
